// File: rtl/dbus_wb_if_pkg.sv
// Shared definitions for the data-bus Wishbone bridge: FSM encodings and the zero word.
package dbus_wb_if_pkg;

  typedef enum logic [1:0] {
    IDLE           = 2'd0,
    BUSY           = 2'd1,
    WAIT_FOR_STALL = 2'd2
  } bus_state_e;

  localparam logic [31:0] ZeroWord = 32'h0000_0000;

endpackage

// File: rtl/bus_timeout_cnt.sv
// Counts BUSY cycles without ack; expired flags the last allowed cycle (count == TIMEOUT-1).
// Latency: expired is combinational from the count; clr wins over en.
module bus_timeout_cnt #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst || clr) begin
      cnt <= '0;
    end else if (en && !expired) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign expired = (cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/dbus_wb_if.sv
// Memory-stage to Wishbone B4 classic master; one bus cycle per request, read data same cycle as ack.
// Stalls the pipeline while a cycle is outstanding; aborts on flush or after TIMEOUT cycles without ack.
module dbus_wb_if
  import dbus_wb_if_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [5:0]        stall_i,
  input  logic              flush_i,
  input  logic              cpu_ce_i,
  input  logic              cpu_we_i,
  input  logic [31:0]       cpu_addr_i,
  input  logic [3:0]        cpu_sel_i,
  input  logic [31:0]       cpu_data_i,
  output logic [31:0]       cpu_data_o,
  output logic              stallreq_o,
  output logic              bus_err_o,
  output logic [ADDR_W-1:0] wb_adr_o,
  output logic [31:0]       wb_dat_o,
  output logic              wb_we_o,
  output logic [3:0]        wb_sel_o,
  output logic              wb_stb_o,
  output logic              wb_cyc_o,
  input  logic [31:0]       wb_dat_i,
  input  logic              wb_ack_i
);

  bus_state_e  state;
  logic [31:0] rd_buf;
  logic        tmo_expired;
  logic        tmo_en;
  logic        tmo_clr;
  logic        timeout;

  // Counter sits at zero whenever no cycle is outstanding, so entering BUSY always starts fresh.
  assign tmo_clr = (state != BUSY);
  assign tmo_en  = (state == BUSY) && !wb_ack_i && !flush_i;
  assign timeout = tmo_en && tmo_expired;

  bus_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clr     (tmo_clr),
    .en      (tmo_en),
    .expired (tmo_expired)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      wb_adr_o  <= '0;
      wb_dat_o  <= ZeroWord;
      wb_we_o   <= 1'b0;
      wb_sel_o  <= 4'b0000;
      wb_stb_o  <= 1'b0;
      wb_cyc_o  <= 1'b0;
      rd_buf    <= ZeroWord;
      bus_err_o <= 1'b0;
    end else begin
      bus_err_o <= 1'b0;
      case (state)
        IDLE: begin
          if (cpu_ce_i && !flush_i) begin
            wb_adr_o <= ADDR_W'(cpu_addr_i);
            wb_dat_o <= cpu_data_i;
            wb_we_o  <= cpu_we_i;
            wb_sel_o <= cpu_sel_i;
            wb_stb_o <= 1'b1;
            wb_cyc_o <= 1'b1;
            state    <= BUSY;
          end
        end
        BUSY: begin
          if (flush_i || wb_ack_i || timeout) begin
            wb_adr_o <= '0;
            wb_dat_o <= ZeroWord;
            wb_we_o  <= 1'b0;
            wb_sel_o <= 4'b0000;
            wb_stb_o <= 1'b0;
            wb_cyc_o <= 1'b0;
          end
          if (flush_i) begin
            rd_buf <= ZeroWord;
            state  <= IDLE;
          end else if (wb_ack_i) begin
            // Writes keep rd_buf at zero so nothing leaks back to the pipeline.
            rd_buf <= wb_we_o ? ZeroWord : wb_dat_i;
            state  <= (stall_i != 6'b0) ? WAIT_FOR_STALL : IDLE;
          end else if (timeout) begin
            rd_buf    <= ZeroWord;
            bus_err_o <= 1'b1;
            state     <= IDLE;
          end
        end
        WAIT_FOR_STALL: begin
          if (stall_i == 6'b0) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    stallreq_o = 1'b0;
    cpu_data_o = ZeroWord;
    case (state)
      IDLE: stallreq_o = cpu_ce_i && !flush_i;
      BUSY: begin
        stallreq_o = !(wb_ack_i || flush_i || timeout);
        if (wb_ack_i && !flush_i && !wb_we_o) begin
          cpu_data_o = wb_dat_i;
        end
      end
      WAIT_FOR_STALL: cpu_data_o = rd_buf;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dbus_wb_if.sv
// Directed bench for dbus_wb_if: inputs change 1ns after posedge, outputs checked at negedge.
module tb_dbus_wb_if;
  import dbus_wb_if_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [5:0]  stall_i = '0;
  logic        flush_i = 1'b0;
  logic        cpu_ce_i = 1'b0;
  logic        cpu_we_i = 1'b0;
  logic [31:0] cpu_addr_i = '0;
  logic [3:0]  cpu_sel_i = '0;
  logic [31:0] cpu_data_i = '0;
  logic [31:0] cpu_data_o;
  logic        stallreq_o;
  logic        bus_err_o;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic        wb_we_o;
  logic [3:0]  wb_sel_o;
  logic        wb_stb_o;
  logic        wb_cyc_o;
  logic [31:0] wb_dat_i = '0;
  logic        wb_ack_i = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  dbus_wb_if #(.TIMEOUT(8), .ADDR_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .stall_i    (stall_i),
    .flush_i    (flush_i),
    .cpu_ce_i   (cpu_ce_i),
    .cpu_we_i   (cpu_we_i),
    .cpu_addr_i (cpu_addr_i),
    .cpu_sel_i  (cpu_sel_i),
    .cpu_data_i (cpu_data_i),
    .cpu_data_o (cpu_data_o),
    .stallreq_o (stallreq_o),
    .bus_err_o  (bus_err_o),
    .wb_adr_o   (wb_adr_o),
    .wb_dat_o   (wb_dat_o),
    .wb_we_o    (wb_we_o),
    .wb_sel_o   (wb_sel_o),
    .wb_stb_o   (wb_stb_o),
    .wb_cyc_o   (wb_cyc_o),
    .wb_dat_i   (wb_dat_i),
    .wb_ack_i   (wb_ack_i)
  );

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic issue(input logic we, input logic [31:0] addr, input logic [3:0] sel,
                       input logic [31:0] data);
    cpu_ce_i   = 1'b1;
    cpu_we_i   = we;
    cpu_addr_i = addr;
    cpu_sel_i  = sel;
    cpu_data_i = data;
  endtask

  task automatic idle_inputs();
    cpu_ce_i = 1'b0; cpu_we_i = 1'b0; cpu_addr_i = '0; cpu_sel_i = '0; cpu_data_i = '0;
    wb_ack_i = 1'b0; wb_dat_i = '0; flush_i = 1'b0; stall_i = '0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle_inputs();
    next_cycle();
    next_cycle();
    mid();
    n_tests++;
    if ({wb_cyc_o, wb_stb_o, wb_we_o} !== 3'b000) begin
      n_fail++; $display("FAIL reset_ctl: got cyc/stb/we=%b want 000", {wb_cyc_o, wb_stb_o, wb_we_o});
    end
    n_tests++;
    if ({wb_adr_o, wb_dat_o, wb_sel_o} !== 68'h0) begin
      n_fail++; $display("FAIL reset_bus: got adr=%h dat=%h sel=%b want 0", wb_adr_o, wb_dat_o, wb_sel_o);
    end
    n_tests++;
    if ({bus_err_o, stallreq_o, cpu_data_o} !== 34'h0) begin
      n_fail++; $display("FAIL reset_cpu: got err=%b stallreq=%b data=%h want 0", bus_err_o, stallreq_o, cpu_data_o);
    end
    n_tests++;
    if (dut.state !== IDLE) begin
      n_fail++; $display("FAIL reset_state: got %0d want IDLE", dut.state);
    end
    rst = 1'b1;
  endtask

  task automatic test_read();
    next_cycle();
    issue(1'b0, 32'h8000_0010, 4'hF, 32'h0);
    mid();
    n_tests++;
    if (stallreq_o !== 1'b1) begin
      n_fail++; $display("FAIL rd_idle_stallreq: got %b want 1", stallreq_o);
    end
    for (int c = 1; c <= 3; c++) begin
      next_cycle();
      if (c == 3) begin wb_ack_i = 1'b1; wb_dat_i = 32'hDEAD_BEEF; end
      mid();
      n_tests++;
      if ({wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o} !== {3'b110, 32'h8000_0010}) begin
        n_fail++; $display("FAIL rd_busy%0d_bus: got cyc/stb/we=%b adr=%h want 110 80000010", c,
                           {wb_cyc_o, wb_stb_o, wb_we_o}, wb_adr_o);
      end
      n_tests++;
      if (stallreq_o !== (c != 3)) begin
        n_fail++; $display("FAIL rd_busy%0d_stallreq: got %b want %b", c, stallreq_o, (c != 3));
      end
      n_tests++;
      if (cpu_data_o !== ((c == 3) ? 32'hDEAD_BEEF : 32'h0)) begin
        n_fail++; $display("FAIL rd_busy%0d_data: got %h want %h", c, cpu_data_o,
                           (c == 3) ? 32'hDEAD_BEEF : 32'h0);
      end
    end
    next_cycle();
    idle_inputs();
    mid();
    n_tests++;
    if (dut.state !== IDLE || wb_cyc_o !== 1'b0 || wb_stb_o !== 1'b0 || wb_adr_o !== 32'h0) begin
      n_fail++; $display("FAIL rd_after: got state=%0d cyc=%b stb=%b adr=%h want IDLE 0 0 0",
                         dut.state, wb_cyc_o, wb_stb_o, wb_adr_o);
    end
    n_tests++;
    if (cpu_data_o !== 32'h0) begin
      n_fail++; $display("FAIL rd_after_data: got %h want 0", cpu_data_o);
    end
  endtask

  task automatic test_read_stall();
    next_cycle();
    issue(1'b0, 32'h8000_0010, 4'hF, 32'h0);
    next_cycle();
    wb_ack_i = 1'b1; wb_dat_i = 32'hDEAD_BEEF; stall_i = 6'b000011;
    mid();
    n_tests++;
    if (cpu_data_o !== 32'hDEAD_BEEF || stallreq_o !== 1'b0) begin
      n_fail++; $display("FAIL rs_ack: got data=%h stallreq=%b want deadbeef 0", cpu_data_o, stallreq_o);
    end
    for (int c = 1; c <= 5; c++) begin
      next_cycle();
      wb_ack_i = 1'b0; wb_dat_i = 32'h1111_2222;
      stall_i = (c == 5) ? 6'b0 : 6'b000011;
      mid();
      n_tests++;
      if (dut.state !== WAIT_FOR_STALL || cpu_data_o !== 32'hDEAD_BEEF) begin
        n_fail++; $display("FAIL rs_wait%0d: got state=%0d data=%h want WAIT_FOR_STALL deadbeef",
                           c, dut.state, cpu_data_o);
      end
      n_tests++;
      if ({wb_cyc_o, wb_stb_o, stallreq_o} !== 3'b000) begin
        n_fail++; $display("FAIL rs_wait%0d_ctl: got cyc/stb/stallreq=%b want 000", c,
                           {wb_cyc_o, wb_stb_o, stallreq_o});
      end
    end
    next_cycle();
    idle_inputs();
    mid();
    n_tests++;
    if (dut.state !== IDLE || cpu_data_o !== 32'h0) begin
      n_fail++; $display("FAIL rs_release: got state=%0d data=%h want IDLE 0", dut.state, cpu_data_o);
    end
  endtask

  task automatic test_write();
    next_cycle();
    issue(1'b1, 32'h8000_0020, 4'b0011, 32'h1234_5678);
    for (int c = 1; c <= 2; c++) begin
      next_cycle();
      if (c == 2) begin wb_ack_i = 1'b1; wb_dat_i = 32'hCAFE_F00D; end
      mid();
      n_tests++;
      if ({wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_dat_o, wb_adr_o} !==
          {3'b111, 4'b0011, 32'h1234_5678, 32'h8000_0020}) begin
        n_fail++; $display("FAIL wr_busy%0d: got cyc/stb/we=%b sel=%b dat=%h adr=%h want 111 0011 12345678 80000020",
                           c, {wb_cyc_o, wb_stb_o, wb_we_o}, wb_sel_o, wb_dat_o, wb_adr_o);
      end
      n_tests++;
      if (cpu_data_o !== 32'h0) begin
        n_fail++; $display("FAIL wr_busy%0d_data: got %h want 0", c, cpu_data_o);
      end
    end
    next_cycle();
    idle_inputs();
    mid();
    n_tests++;
    if ({wb_cyc_o, wb_we_o, wb_sel_o, wb_dat_o} !== 38'h0 || cpu_data_o !== 32'h0) begin
      n_fail++; $display("FAIL wr_after: got cyc=%b we=%b sel=%b dat=%h data=%h want all 0",
                         wb_cyc_o, wb_we_o, wb_sel_o, wb_dat_o, cpu_data_o);
    end
  endtask

  task automatic test_flush_ack();
    next_cycle();
    issue(1'b0, 32'h8000_0030, 4'hF, 32'h0);
    next_cycle();
    next_cycle();
    wb_ack_i = 1'b1; wb_dat_i = 32'h55AA_55AA; flush_i = 1'b1; stall_i = 6'b000100;
    mid();
    n_tests++;
    if (cpu_data_o !== 32'h0 || stallreq_o !== 1'b0) begin
      n_fail++; $display("FAIL fl_ack: got data=%h stallreq=%b want 0 0", cpu_data_o, stallreq_o);
    end
    // Request still presented alongside flush in IDLE: must be ignored.
    next_cycle();
    wb_ack_i = 1'b0; stall_i = '0;
    mid();
    n_tests++;
    if (wb_cyc_o !== 1'b0 || dut.state !== IDLE || dut.rd_buf !== 32'h0) begin
      n_fail++; $display("FAIL fl_after: got cyc=%b state=%0d rd_buf=%h want 0 IDLE 0",
                         wb_cyc_o, dut.state, dut.rd_buf);
    end
    n_tests++;
    if (stallreq_o !== 1'b0 || cpu_data_o !== 32'h0) begin
      n_fail++; $display("FAIL fl_idle_req: got stallreq=%b data=%h want 0 0", stallreq_o, cpu_data_o);
    end
    next_cycle();
    idle_inputs();
    mid();
    n_tests++;
    if (wb_cyc_o !== 1'b0 || wb_stb_o !== 1'b0) begin
      n_fail++; $display("FAIL fl_ignored: got cyc=%b stb=%b want 0 0", wb_cyc_o, wb_stb_o);
    end
  endtask

  task automatic test_timeout();
    next_cycle();
    issue(1'b0, 32'h8000_0040, 4'hF, 32'h0);
    for (int c = 1; c <= 8; c++) begin
      next_cycle();
      mid();
      n_tests++;
      if (wb_cyc_o !== 1'b1 || bus_err_o !== 1'b0 || stallreq_o !== (c != 8)) begin
        n_fail++; $display("FAIL to_busy%0d: got cyc=%b err=%b stallreq=%b want 1 0 %b",
                           c, wb_cyc_o, bus_err_o, stallreq_o, (c != 8));
      end
    end
    next_cycle();
    idle_inputs();
    mid();
    n_tests++;
    if (wb_cyc_o !== 1'b0 || wb_stb_o !== 1'b0 || bus_err_o !== 1'b1 || dut.state !== IDLE) begin
      n_fail++; $display("FAIL to_abort: got cyc=%b stb=%b err=%b state=%0d want 0 0 1 IDLE",
                         wb_cyc_o, wb_stb_o, bus_err_o, dut.state);
    end
    next_cycle();
    mid();
    n_tests++;
    if (bus_err_o !== 1'b0 || stallreq_o !== 1'b0) begin
      n_fail++; $display("FAIL to_pulse: got err=%b stallreq=%b want 0 0", bus_err_o, stallreq_o);
    end
  endtask

  task automatic test_reset_busy();
    next_cycle();
    issue(1'b1, 32'h8000_0050, 4'b1100, 32'hA5A5_0F0F);
    next_cycle();
    mid();
    n_tests++;
    if (wb_cyc_o !== 1'b1 || wb_we_o !== 1'b1) begin
      n_fail++; $display("FAIL rb_busy: got cyc=%b we=%b want 1 1", wb_cyc_o, wb_we_o);
    end
    next_cycle();
    rst = 1'b0;
    next_cycle();
    idle_inputs();
    rst = 1'b1;
    mid();
    n_tests++;
    if ({wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o, wb_dat_o} !== 71'h0 || dut.state !== IDLE) begin
      n_fail++; $display("FAIL rb_after: got cyc/stb/we=%b sel=%b adr=%h dat=%h state=%0d want 0 IDLE",
                         {wb_cyc_o, wb_stb_o, wb_we_o}, wb_sel_o, wb_adr_o, wb_dat_o, dut.state);
    end
  endtask

  always @(negedge clk) begin
    if (rst && wb_stb_o && !wb_cyc_o) begin
      n_tests++;
      n_fail++;
      $display("FAIL stb_without_cyc: got stb=1 cyc=0 want cyc=1");
    end
  end

  initial begin
    test_reset();
    test_read();
    test_read_stall();
    test_write();
    test_flush_ack();
    test_timeout();
    test_reset_busy();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dbus_wb_if.md
DBUS_WB_IF -- requirements
Module: dbus_wb_if

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255: maximum cycles BUSY waits for wb_ack_i before aborting.
REQ-002 SHALL have parameter ADDR_W, default 32: Wishbone address width.
REQ-003 SHALL have port clk, in, 1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, in, 1: synchronous, active-low reset.
REQ-005 SHALL have port stall_i, in, 6: pipeline stall vector; any bit set means the pipeline is held.
REQ-006 SHALL have port flush_i, in, 1: pipeline flush due to an exception.
REQ-007 SHALL have ports cpu_ce_i (in, 1), cpu_we_i (in, 1), cpu_addr_i (in, 32), cpu_sel_i (in, 4) and cpu_data_i (in, 32): the access request from the memory-access stage.
REQ-008 SHALL have port cpu_data_o, out, 32: read data returned to the memory-access stage.
REQ-009 SHALL have port stallreq_o, out, 1: pipeline stall request.
REQ-010 SHALL have port bus_err_o, out, 1: one-cycle pulse on timeout.
REQ-011 SHALL have ports wb_adr_o (out, ADDR_W), wb_dat_o (out, 32), wb_we_o (out, 1), wb_sel_o (out, 4), wb_stb_o (out, 1), wb_cyc_o (out, 1), wb_dat_i (in, 32) and wb_ack_i (in, 1): the Wishbone B4 classic master.

Function
REQ-012 SHALL implement FSM states IDLE, BUSY, WAIT_FOR_STALL.
REQ-013 IDLE with cpu_ce_i=1 and flush_i=0 SHALL, on the next edge, register wb_adr_o/dat_o/we_o/sel_o from the cpu_* inputs, set cyc=stb=1, clear the timeout counter and go to BUSY.
REQ-014 IDLE SHALL ignore requests while flush_i=1.
REQ-015 BUSY with wb_ack_i=1 SHALL, on that edge, drop cyc/stb/we, zero sel/adr/dat, latch wb_dat_i into rd_buf, and go to WAIT_FOR_STALL if stall_i!=0, else to IDLE.
REQ-016 BUSY with flush_i=1 SHALL abort the cycle: drop cyc/stb/we, zero rd_buf, go to IDLE; flush_i has priority over a simultaneous wb_ack_i.
REQ-017 BUSY SHALL increment the timeout counter each cycle without ack; on reaching TIMEOUT it SHALL abort as in REQ-016, pulse bus_err_o for one cycle and go to IDLE.
REQ-018 WAIT_FOR_STALL SHALL hold cyc=stb=0 and go to IDLE when stall_i==0.
REQ-019 stallreq_o SHALL be combinational: 1 in IDLE when cpu_ce_i=1 and flush_i=0; 1 in BUSY unless wb_ack_i=1 or flush_i=1 or timeout; 0 otherwise.
REQ-020 cpu_data_o SHALL be combinational: wb_dat_i in BUSY when wb_ack_i=1; rd_buf in WAIT_FOR_STALL; 0 otherwise.
REQ-021 Each request SHALL produce exactly one Wishbone cycle; wb_stb_o SHALL never be asserted without wb_cyc_o.
REQ-022 Writes SHALL return cpu_data_o=0 in all states.

Reset
REQ-023 On rst=0 at an edge, the block SHALL go to IDLE; all wb_* outputs, rd_buf and the timeout counter SHALL be 0; bus_err_o SHALL be 0.
REQ-024 Reset while in BUSY SHALL abandon the cycle immediately; wb_cyc_o SHALL be 0 on the following cycle.

Structure
REQ-025 The FSM state encodings and the ZeroWord constant SHALL live in the shared defines package; TIMEOUT stays local.
REQ-026 The timeout counter SHALL be a sub-module, bus_timeout_cnt, with inputs clr and en and output expired.

Verification
REQ-027 Read, stall_i=0: addr 0x80000010, ack on the 3rd BUSY cycle, wb_dat_i=0xDEADBEEF -> cpu_data_o=0xDEADBEEF in the ack cycle, stallreq_o=0 in that cycle, IDLE next.
REQ-028 Read with stall_i=6'b000011 held 4 cycles after ack -> WAIT_FOR_STALL, cpu_data_o=0xDEADBEEF stable for 4 cycles, then IDLE.
REQ-029 Write, sel=4'b0011, data 0x12345678 -> wb_we_o=1, wb_sel_o=0011, wb_dat_o=0x12345678 until ack; cpu_data_o=0.
REQ-030 flush_i=1 together with ack in BUSY -> cyc=0 next cycle, rd_buf=0, no data returned.
REQ-031 No ack, TIMEOUT=8 -> abort after 8 BUSY cycles, bus_err_o high for exactly 1 cycle, stallreq_o released.
REQ-032 rst=0 mid-BUSY -> all wb_* outputs 0 next cycle, state IDLE.
